// File: rtl/cu_pkg.sv
// cu_pkg -- shared definitions for the multicycle control unit.
//   state_t     : FSM state encodings (visible on state_o)
//   CLS_*       : instruction class codes (top nibble of the instruction)
//   CB_*        : bit positions inside the datapath control word
//   is_exec_cls : classes that continue into EXEC after DECODE
package cu_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_FETCH    = 3'd1,
    ST_IR_LD    = 3'd2,
    ST_DECODE   = 3'd3,
    ST_EXEC     = 3'd4,
    ST_MEM      = 3'd5,
    ST_MEM_DONE = 3'd6,
    ST_HALT     = 3'd7
  } state_t;

  // Plain constants rather than an enum: undefined class codes must be
  // representable without an illegal enum cast.
  localparam logic [3:0] CLS_NOP   = 4'h0;
  localparam logic [3:0] CLS_ALU   = 4'h1;
  localparam logic [3:0] CLS_LOAD  = 4'h2;
  localparam logic [3:0] CLS_STORE = 4'h3;
  localparam logic [3:0] CLS_JMP   = 4'h4;
  localparam logic [3:0] CLS_JCOND = 4'h5;
  localparam logic [3:0] CLS_HALT  = 4'hF;

  localparam int unsigned CB_PC_INC   = 0;
  localparam int unsigned CB_IR_LOAD  = 1;
  localparam int unsigned CB_MAR_LOAD = 2;
  localparam int unsigned CB_MEM_RD   = 3;
  localparam int unsigned CB_MEM_WR   = 4;
  localparam int unsigned CB_ALU_EN   = 5;
  localparam int unsigned CB_ACC_LOAD = 6;
  localparam int unsigned CB_PC_LOAD  = 7;
  localparam int unsigned CB_MDR_LOAD = 8;
  localparam int unsigned CB_COUNT    = 9;

  function automatic logic is_exec_cls(input logic [3:0] cls);
    return (cls == CLS_ALU) || (cls == CLS_LOAD) || (cls == CLS_STORE) ||
           (cls == CLS_JMP) || (cls == CLS_JCOND);
  endfunction

endpackage

// File: rtl/cu_decode.sv
// cu_decode -- combinational decode for cu_multicycle.
//   Instruction side: extracts the class nibble and the selected condition
//   flag from the live instruction/flags (the FSM latches them in DECODE).
//   Output side: Moore decode of the registered state, latched class and
//   latched branch_taken into control_signal, mem_req and halted.
// Ports:
//   data_from_ir [IR_W]   in   current instruction
//   flags [FLAG_W]        in   ALU status flags
//   state                 in   registered FSM state
//   cls_q [4]             in   class latched in DECODE
//   taken_q               in   branch_taken latched in DECODE
//   ir_class [4]          out  class of data_from_ir
//   ir_taken              out  flags[cond index], 0 when index >= FLAG_W
//   control_signal [CTRL_W] out datapath control word
//   mem_req, halted       out  memory request / halt indication
module cu_decode
  import cu_pkg::*;
#(
  parameter int IR_W   = 8,
  parameter int FLAG_W = 8,
  parameter int CTRL_W = 32
) (
  input  logic [IR_W-1:0]   data_from_ir,
  input  logic [FLAG_W-1:0] flags,
  input  state_t            state,
  input  logic [3:0]        cls_q,
  input  logic              taken_q,
  output logic [3:0]        ir_class,
  output logic              ir_taken,
  output logic [CTRL_W-1:0] control_signal,
  output logic              mem_req,
  output logic              halted
);

  logic [2:0]          cond_idx;
  logic [CB_COUNT-1:0] bits;
  logic                unused_ir_bits;

  assign ir_class       = data_from_ir[IR_W-1 -: 4];
  assign cond_idx       = data_from_ir[2:0];
  assign unused_ir_bits = ^data_from_ir[IR_W-5:3];

  // Scan instead of direct indexing so a condition index beyond FLAG_W
  // reads as 0 rather than out of range.
  always_comb begin
    ir_taken = 1'b0;
    for (int i = 0; i < FLAG_W; i++) begin
      if (i < 8 && int'(cond_idx) == i) ir_taken = flags[i];
    end
  end

  // NOTE: every output gets a default before the case so no path leaves
  // a value unassigned -- that is what keeps this logic free of latches.
  always_comb begin
    bits    = '0;
    mem_req = 1'b0;
    halted  = 1'b0;
    unique case (state)
      ST_FETCH: begin
        mem_req         = 1'b1;
        bits[CB_MEM_RD] = 1'b1;
      end
      ST_IR_LD: begin
        bits[CB_IR_LOAD] = 1'b1;
        bits[CB_PC_INC]  = 1'b1;
      end
      ST_EXEC: begin
        if (cls_q == CLS_ALU) begin
          bits[CB_ALU_EN]   = 1'b1;
          bits[CB_ACC_LOAD] = 1'b1;
        end else if (cls_q == CLS_JMP) begin
          bits[CB_PC_LOAD] = 1'b1;
        end else if (cls_q == CLS_JCOND) begin
          bits[CB_PC_LOAD] = taken_q;
        end else if (cls_q == CLS_LOAD || cls_q == CLS_STORE) begin
          bits[CB_MAR_LOAD] = 1'b1;
        end
      end
      ST_MEM: begin
        mem_req = 1'b1;
        if (cls_q == CLS_LOAD) bits[CB_MEM_RD] = 1'b1;
        else                   bits[CB_MEM_WR] = 1'b1;
      end
      ST_MEM_DONE: begin
        if (cls_q == CLS_LOAD) begin
          bits[CB_MDR_LOAD] = 1'b1;
          bits[CB_ACC_LOAD] = 1'b1;
        end
      end
      ST_HALT: halted = 1'b1;
      default: ;
    endcase
  end

  assign control_signal = CTRL_W'(bits);

endmodule

// File: rtl/cu_multicycle.sv
// cu_multicycle -- multicycle CPU control unit (FSM + memory watchdog).
// Configuration macro: CU_MEM_TIMEOUT_EN enables the memory-wait watchdog;
// without it waits are unbounded and bus_err is tied 0.
// Ports:
//   clk, rst (sync, active-high)
//   data_from_ir [IR_W]     instruction, sampled only in DECODE
//   flags [FLAG_W]          ALU flags, sampled only in DECODE
//   mem_ack                 memory completion (ignored unless mem_req)
//   control_signal [CTRL_W] datapath control word
//   mem_req                 memory request, held until mem_ack
//   state_o [3]             current state encoding
//   halted                  high in HALT
//   bus_err                 sticky watchdog timeout
//   illegal_op              one-cycle pulse for an undefined class
// All outputs decode registered state only. illegal_op is registered at
// the end of the offending DECODE, so its pulse lines up with the first
// cycle of the following FETCH.
module cu_multicycle
  import cu_pkg::*;
#(
  parameter int IR_W        = 8,
  parameter int FLAG_W      = 8,
  parameter int CTRL_W      = 32,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [IR_W-1:0]   data_from_ir,
  input  logic [FLAG_W-1:0] flags,
  input  logic              mem_ack,
  output logic [CTRL_W-1:0] control_signal,
  output logic              mem_req,
  output logic [2:0]        state_o,
  output logic              halted,
  output logic              bus_err,
  output logic              illegal_op
);

  state_t     state;
  logic [3:0] cls_q;
  logic       taken_q;
  logic [3:0] ir_class;
  logic       ir_taken;
  logic       waiting;
  logic       wd_timeout;

  cu_decode #(.IR_W(IR_W), .FLAG_W(FLAG_W), .CTRL_W(CTRL_W)) u_decode (
    .data_from_ir   (data_from_ir),
    .flags          (flags),
    .state          (state),
    .cls_q          (cls_q),
    .taken_q        (taken_q),
    .ir_class       (ir_class),
    .ir_taken       (ir_taken),
    .control_signal (control_signal),
    .mem_req        (mem_req),
    .halted         (halted)
  );

  assign state_o = state;
  assign waiting = (state == ST_FETCH) || (state == ST_MEM);

`ifdef CU_MEM_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
  logic [WD_W-1:0] wd_cnt;

  // Counter is zero in every non-waiting state, hence zero on entry to
  // FETCH or MEM; it counts cycles spent waiting without an ack.
  assign wd_timeout = waiting && !mem_ack && (wd_cnt == WD_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      wd_cnt  <= '0;
      bus_err <= 1'b0;
    end else begin
      if (waiting && !mem_ack) wd_cnt <= wd_cnt + 1'b1;
      else                     wd_cnt <= '0;
      if (wd_timeout) bus_err <= 1'b1;
    end
  end
`else
  assign wd_timeout = 1'b0;
  assign bus_err    = 1'b0;
`endif

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      cls_q      <= CLS_NOP;
      taken_q    <= 1'b0;
      illegal_op <= 1'b0;
    end else begin
      illegal_op <= 1'b0;
      unique case (state)
        ST_IDLE:  state <= ST_FETCH;
        ST_FETCH: begin
          if (mem_ack)         state <= ST_IR_LD;
          else if (wd_timeout) state <= ST_HALT;
        end
        ST_IR_LD: state <= ST_DECODE;
        ST_DECODE: begin
          cls_q   <= ir_class;
          taken_q <= ir_taken;
          if (ir_class == CLS_NOP) begin
            state <= ST_FETCH;
          end else if (ir_class == CLS_HALT) begin
            state <= ST_HALT;
          end else if (is_exec_cls(ir_class)) begin
            state <= ST_EXEC;
          end else begin
            state      <= ST_FETCH;
            illegal_op <= 1'b1;
          end
        end
        ST_EXEC: begin
          if (cls_q == CLS_LOAD || cls_q == CLS_STORE) state <= ST_MEM;
          else                                         state <= ST_FETCH;
        end
        ST_MEM: begin
          if (mem_ack)         state <= ST_MEM_DONE;
          else if (wd_timeout) state <= ST_HALT;
        end
        ST_MEM_DONE: state <= ST_FETCH;
        ST_HALT:     state <= ST_HALT;
        default:     state <= ST_IDLE;
      endcase
    end
  end

endmodule
